rmii_rx: RTL and testbench
==========================

Name: rmii_rx

Overview:
- RMII receive front end for the LAN8720 PHY at 100 Mb/s.
- Samples the 2-bit `rxd`, `crs_dv` and `rx_er` on every `clk`, hunts the preamble/SFD, assembles dibits LSB-first into bytes, and marks frame boundaries.
- Feeds the Ethernet frame parser directly. It emits the SFD byte 0xD5 first, followed by every frame byte through the FCS, each as a one-cycle `byte_valid` pulse.

Parameters:
- MIN_PREAMBLE_DIBITS, 4, number of consecutive 2'b01 dibits required before an SFD is accepted.
- MAX_FRAME_BYTES, 1522, post-SFD byte limit. Reaching it truncates the frame and flags an error.

Ports:
- clk  in  1  50 MHz RMII reference clock
- resetn  in  1  asynchronous active-low reset
- crs_dv  in  1  PHY carrier sense / data valid
- rxd  in  2  PHY receive dibit, rxd[0] first in time
- rx_er  in  1  PHY receive error
- rx_byte  out  8  assembled byte, valid only with byte_valid
- byte_valid  out  1  one-cycle pulse per byte (SFD and post-SFD bytes only)
- frame_active  out  1  high from the SFD pulse until frame end
- frame_end  out  1  one-cycle pulse when a frame that reached DATA ends
- frame_error  out  1  valid with frame_end: rx_er seen, partial byte, or truncation

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; all outputs 0; dibit counter, byte counter, preamble counter, shift register and error flag cleared.
  - Reset mid-frame abandons the frame silently: no frame_end pulse.
- Registering and latency:
  - All outputs are registered.
  - A byte's 4th dibit sampled on edge N gives rx_byte/byte_valid high for the cycle after edge N (1-cycle latency).
  - byte_valid never asserts on two consecutive cycles (min spacing 4 clk).
- Byte assembly:
  - Dibit k (k=0..3) lands in byte bits [2k+1:2k].
  - Dibit counter wraps 3→0 on byte emit.
- States: IDLE, PREAMBLE, DATA, WAIT_IDLE.
- IDLE:
  - crs_dv=1 & rxd=2'b01 → PREAMBLE, preamble count=1.
  - crs_dv=1 & other rxd → WAIT_IDLE.
  - Otherwise stay.
- PREAMBLE:
  - rxd=01: count++, saturating at MIN_PREAMBLE_DIBITS.
  - rxd=11 & count≥MIN_PREAMBLE_DIBITS: emit rx_byte=8'hD5, byte_valid=1, frame_active=1; dibit counter=0, byte counter=0, error flag=0 → DATA.
  - rxd=11 with short preamble, rxd=10 (false carrier), or rxd=00 with crs_dv=1 → WAIT_IDLE.
  - crs_dv low two consecutive cycles → IDLE.
- DATA:
  - Every cycle the dibit is shifted in, including a cycle with crs_dv=0.
  - Frame end: crs_dv=0 on two consecutive cycles. A single low cycle (PHY CRS_DV toggling at nibble rate) is not an end; that dibit is valid data.
  - On frame end: the dibit shifted in on the second low cycle is discarded. Pulse frame_end; frame_active→0; → IDLE.
  - frame_error = error flag OR dibit counter≠0 excluding the discarded dibit (partial byte, which is never emitted).
  - rx_er=1 with crs_dv=1 sets the error flag.
  - Byte counter increments on each post-SFD emit. When it reaches MAX_FRAME_BYTES: emit that byte, set the error flag, pulse frame_end with frame_error=1 on the following cycle, frame_active→0 → WAIT_IDLE. No further bytes are emitted.
- WAIT_IDLE:
  - No outputs.
  - → IDLE after crs_dv=0 on two consecutive cycles.
- Simultaneous events:
  - 4th dibit coinciding with the first low cycle of an end: the byte is emitted normally.
  - rx_er in the same cycle as frame end still sets frame_error.
- Widths:
  - Byte counter 11 bits. Compare with ==, no wrap possible given the limit.
  - Preamble counter saturates, never wraps.

Test Plan:
- Clean frame: 15×01 then 11, then 64 bytes 0x00..0x3F, crs_dv low 2 cycles → first byte_valid 0xD5 one cycle after the 11 dibit; then 0x00..0x3F at 4-cycle spacing; frame_end=1, frame_error=0; total 65 pulses.
- CRS_DV toggle: during the last 8 dibits of the frame, crs_dv alternates 0/1 each cycle with valid rxd → all bytes intact, frame_end only after the two-low-cycle end.
- False carrier / short preamble: crs_dv=1 with rxd=10; separately 2×01 then 11 → no byte_valid, no frame_end; the next clean frame is received normally.
- Error paths: rx_er=1 for one cycle mid-frame → frame_error=1 at frame_end. A frame ending 2 dibits into a byte → the partial byte is not emitted, frame_error=1.
- Truncation with MAX_FRAME_BYTES=16: 40-byte frame → exactly 17 byte_valid pulses (SFD+16), frame_end with frame_error=1, no further pulses until crs_dv idles.
- Reset mid-frame: resetn low after byte 10 → all outputs 0 immediately, no frame_end; a following clean frame is received correctly.

Source files
------------

// File: rtl/rmii_rx.sv
// RMII receive front end (LAN8720, 100 Mb/s).
// Hunts preamble/SFD, assembles LSB-first dibits into bytes and marks frame
// boundaries. The SFD byte 0xD5 is emitted first, then every frame byte
// through the FCS, each as a one-cycle byte_valid pulse. All outputs are
// registered.
module rmii_rx #(
    parameter int MIN_PREAMBLE_DIBITS = 4,
    parameter int MAX_FRAME_BYTES     = 1522
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       crs_dv,
    input  logic [1:0] rxd,
    input  logic       rx_er,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_active,
    output logic       frame_end,
    output logic       frame_error
);

    localparam int               PRE_W    = $clog2(MIN_PREAMBLE_DIBITS + 1);
    localparam logic [PRE_W-1:0] PRE_MIN  = PRE_W'(MIN_PREAMBLE_DIBITS);
    localparam logic [10:0]      BYTE_MAX = 11'(MAX_FRAME_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        WAIT_IDLE
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] pre_cnt;
    logic [1:0]       dibit_cnt;
    logic [10:0]      byte_cnt;
    logic [5:0]       shift_reg;   // first three dibits of the byte in progress
    logic             err_flag;
    logic             low_prev;    // crs_dv was low on the previous sample
    logic             trunc_pend;  // truncated frame: frame_end due next cycle
    logic             idle_end;

    // Carrier is considered gone only after two consecutive low samples;
    // a single low cycle is CRS_DV toggling at nibble rate.
    assign idle_end = !crs_dv && low_prev;

    // Saturating preamble counter increment; never wraps.
    function automatic logic [PRE_W-1:0] pre_inc(input logic [PRE_W-1:0] c);
        return (c >= PRE_MIN) ? c : c + 1'b1;
    endfunction

    // Receive FSM with all outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            pre_cnt      <= '0;
            dibit_cnt    <= '0;
            byte_cnt     <= '0;
            shift_reg    <= '0;
            err_flag     <= 1'b0;
            low_prev     <= 1'b0;
            trunc_pend   <= 1'b0;
            rx_byte      <= '0;
            byte_valid   <= 1'b0;
            frame_active <= 1'b0;
            frame_end    <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_end   <= 1'b0;
            frame_error <= 1'b0;
            low_prev    <= !crs_dv;

            case (state)
                IDLE: begin
                    if (crs_dv) begin
                        if (rxd == 2'b01) begin
                            pre_cnt <= PRE_W'(1);
                            state   <= PREAMBLE;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!crs_dv) begin
                        if (low_prev) state <= IDLE;
                    end else begin
                        case (rxd)
                            2'b01: pre_cnt <= pre_inc(pre_cnt);
                            2'b11: begin
                                if (pre_cnt >= PRE_MIN) begin
                                    rx_byte      <= 8'hD5;
                                    byte_valid   <= 1'b1;
                                    frame_active <= 1'b1;
                                    dibit_cnt    <= '0;
                                    byte_cnt     <= '0;
                                    err_flag     <= 1'b0;
                                    state        <= DATA;
                                end else begin
                                    state <= WAIT_IDLE;
                                end
                            end
                            default: state <= WAIT_IDLE;
                        endcase
                    end
                end

                DATA: begin
                    if (idle_end) begin
                        // The dibit sampled now is discarded; leftover dibits
                        // mean a partial byte, which is never emitted.
                        frame_end    <= 1'b1;
                        frame_error  <= err_flag || (dibit_cnt != 2'd0) || rx_er;
                        frame_active <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        if (rx_er && crs_dv) err_flag <= 1'b1;
                        shift_reg <= {rxd, shift_reg[5:2]};
                        dibit_cnt <= dibit_cnt + 2'd1;
                        if (dibit_cnt == 2'd3) begin
                            rx_byte    <= {rxd, shift_reg};
                            byte_valid <= 1'b1;
                            byte_cnt   <= byte_cnt + 11'd1;
                            if (byte_cnt + 11'd1 == BYTE_MAX) begin
                                err_flag   <= 1'b1;
                                trunc_pend <= 1'b1;
                                state      <= WAIT_IDLE;
                            end
                        end
                    end
                end

                WAIT_IDLE: begin
                    if (trunc_pend) begin
                        frame_end    <= 1'b1;
                        frame_error  <= 1'b1;
                        frame_active <= 1'b0;
                        trunc_pend   <= 1'b0;
                    end
                    if (idle_end) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_rx.sv
// Scoreboard bench for rmii_rx. Instance 0 uses default parameters,
// instance 1 uses MAX_FRAME_BYTES=16; crs_dv is steered to one at a time.
// Frames end the way the PHY ends them: the final data dibit arrives on the
// first crs_dv-low cycle, followed by one more low cycle.
module tb_rmii_rx;

    logic       clk = 1'b0;
    logic       resetn;
    logic       crs_dv;
    logic [1:0] rxd;
    logic       rx_er;
    int         sel;

    logic       cdv0, cdv1;
    logic [7:0] rx_byte0, rx_byte1;
    logic       bv0, bv1, fa0, fa1, fe0, fe1, fr0, fr1;

    assign cdv0 = crs_dv && (sel == 0);
    assign cdv1 = crs_dv && (sel == 1);

    always #10 clk = ~clk;

    rmii_rx dut0 (
        .clk(clk), .resetn(resetn), .crs_dv(cdv0), .rxd(rxd), .rx_er(rx_er),
        .rx_byte(rx_byte0), .byte_valid(bv0), .frame_active(fa0),
        .frame_end(fe0), .frame_error(fr0)
    );

    rmii_rx #(.MAX_FRAME_BYTES(16)) dut1 (
        .clk(clk), .resetn(resetn), .crs_dv(cdv1), .rxd(rxd), .rx_er(rx_er),
        .rx_byte(rx_byte1), .byte_valid(bv1), .frame_active(fa1),
        .frame_end(fe1), .frame_error(fr1)
    );

    // kind 0 = byte pulse (data = byte), kind 1 = frame_end (data = frame_error)
    typedef struct {
        int         inst;
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    int   pulses[2];
    bit   prev_bv[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push(input int s, input int kind, input logic [7:0] data, input int dc);
        exp_t e;
        e.inst = s;
        e.kind = kind;
        e.data = data;
        e.cyc  = cyc + dc;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int s, input int kind, input logic [7:0] data);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL unexpected_output: inst %0d kind %0d data %0h at cycle %0d, expected nothing",
                     s, kind, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.inst != s || e.kind != kind || e.data !== data || e.cyc != cyc) begin
                n_fails++;
                $display("FAIL scoreboard: got inst %0d kind %0d data %0h cycle %0d, expected inst %0d kind %0d data %0h cycle %0d",
                         s, kind, data, cyc, e.inst, e.kind, e.data, e.cyc);
            end
        end
    endtask

    task automatic mon_one(input int s, input logic bv, input logic [7:0] b,
                           input logic fa, input logic fe, input logic fr);
        if (bv) begin
            pulses[s]++;
            chk("byte_spacing", prev_bv[s], 0);
            chk("active_with_byte", fa, 1);
            pop_cmp(s, 0, b);
        end
        if (fe) begin
            chk("inactive_at_end", fa, 0);
            pop_cmp(s, 1, {7'd0, fr});
        end
        prev_bv[s] = bv;
    endtask

    task automatic dib(input int s, input logic c, input logic [1:0] d, input logic e);
        @(negedge clk);
        sel    = s;
        crs_dv = c;
        rxd    = d;
        rx_er  = e;
    endtask

    task automatic idle(input int s, input int n);
        repeat (n) dib(s, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic send_pre(input int s, input int n, input bit expect_sfd);
        repeat (n) dib(s, 1'b1, 2'b01, 1'b0);
        dib(s, 1'b1, 2'b11, 1'b0);
        if (expect_sfd) push(s, 0, 8'hD5, 1);
    endtask

    task automatic send_byte(input int s, input logic [7:0] b, input logic [3:0] cdv,
                             input logic [3:0] er, input bit expect_it);
        for (int k = 0; k < 4; k++) begin
            dib(s, cdv[k], b[2*k +: 2], er[k]);
            if (k == 3 && expect_it) push(s, 0, b, 1);
        end
    endtask

    task automatic send_clean(input int s, input int npre, input int nbytes, input logic [7:0] base);
        logic [7:0] b;
        send_pre(s, npre, 1);
        for (int i = 0; i < nbytes; i++) begin
            b = base + 8'(i);
            send_byte(s, b, (i == nbytes - 1) ? 4'b0111 : 4'b1111, 4'b0000, 1);
        end
        dib(s, 1'b0, 2'b00, 1'b0);
        push(s, 1, 8'h00, 1);
        idle(s, 3);
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int p;
        logic [7:0] b;
        resetn = 1'b0;
        crs_dv = 1'b0;
        rxd    = 2'b00;
        rx_er  = 1'b0;
        sel    = 0;
        pulses[0] = 0;
        pulses[1] = 0;
        prev_bv[0] = 1'b0;
        prev_bv[1] = 1'b0;

        fork
            forever begin
                @(negedge clk);
                mon_one(0, bv0, rx_byte0, fa0, fe0, fr0);
                mon_one(1, bv1, rx_byte1, fa1, fe1, fr1);
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rx_byte0", rx_byte0, 0);
        chk("rst_bv0", bv0, 0);
        chk("rst_fa0", fa0, 0);
        chk("rst_fe0", fe0, 0);
        chk("rst_fr0", fr0, 0);
        chk("rst_rx_byte1", rx_byte1, 0);
        chk("rst_bv1", bv1, 0);
        chk("rst_fa1", fa1, 0);
        chk("rst_fe1", fe1, 0);
        chk("rst_fr1", fr1, 0);
        resetn = 1'b1;
        idle(0, 2);

        // Clean frame: 15 preamble dibits, 64 bytes 0x00..0x3F
        p = pulses[0];
        send_clean(0, 15, 64, 8'h00);
        drain();
        chk("clean_pulse_count", pulses[0] - p, 65);

        // CRS_DV toggling over the last 8 dibits; minimum preamble length
        send_pre(0, 4, 1);
        for (int i = 0; i < 8; i++) begin
            b = 8'h10 + 8'(i);
            send_byte(0, b, (i >= 6) ? 4'b0101 : 4'b1111, 4'b0000, 1);
        end
        dib(0, 1'b0, 2'b00, 1'b0);
        push(0, 1, 8'h00, 1);
        idle(0, 3);
        drain();

        // False carrier, short preambles, then a normal frame
        p = pulses[0];
        repeat (3) dib(0, 1'b1, 2'b10, 1'b0);
        idle(0, 2);
        send_pre(0, 2, 0);
        send_byte(0, 8'h55, 4'b1111, 4'b0000, 0);
        idle(0, 3);
        send_pre(0, 3, 0);
        send_byte(0, 8'hAA, 4'b1111, 4'b0000, 0);
        idle(0, 3);
        send_clean(0, 5, 4, 8'hE0);
        drain();
        chk("false_carrier_pulse_count", pulses[0] - p, 5);

        // rx_er for one dibit mid-frame
        send_pre(0, 4, 1);
        for (int i = 0; i < 6; i++) begin
            b = 8'h20 + 8'(i);
            send_byte(0, b, (i == 5) ? 4'b0111 : 4'b1111, (i == 2) ? 4'b0010 : 4'b0000, 1);
        end
        dib(0, 1'b0, 2'b00, 1'b0);
        push(0, 1, 8'h01, 1);
        idle(0, 3);
        drain();

        // Frame ending two dibits into a byte
        send_pre(0, 4, 1);
        for (int i = 0; i < 3; i++) begin
            b = 8'h30 + 8'(i);
            send_byte(0, b, 4'b1111, 4'b0000, 1);
        end
        dib(0, 1'b1, 2'b11, 1'b0);
        dib(0, 1'b0, 2'b10, 1'b0);
        dib(0, 1'b0, 2'b00, 1'b0);
        push(0, 1, 8'h01, 1);
        idle(0, 3);
        drain();

        // Truncation on the MAX_FRAME_BYTES=16 instance with a 40-byte frame
        p = pulses[1];
        send_pre(1, 8, 1);
        for (int i = 0; i < 40; i++) begin
            b = 8'h80 + 8'(i);
            send_byte(1, b, (i == 39) ? 4'b0111 : 4'b1111, 4'b0000, i < 16);
            if (i == 15) push(1, 1, 8'h01, 2);
        end
        dib(1, 1'b0, 2'b00, 1'b0);
        idle(1, 3);
        drain();
        chk("trunc_pulse_count", pulses[1] - p, 17);

        // Reset in the middle of a frame, then a clean frame
        send_pre(0, 6, 1);
        for (int i = 0; i < 10; i++) begin
            b = 8'h40 + 8'(i);
            send_byte(0, b, 4'b1111, 4'b0000, 1);
        end
        dib(0, 1'b1, 2'b01, 1'b0);
        dib(0, 1'b1, 2'b10, 1'b0);
        #2;
        chk("active_before_reset", fa0, 1);
        resetn = 1'b0;
        #1;
        chk("midrst_fa0", fa0, 0);
        chk("midrst_bv0", bv0, 0);
        chk("midrst_fe0", fe0, 0);
        chk("midrst_fr0", fr0, 0);
        chk("midrst_rx_byte0", rx_byte0, 0);
        crs_dv = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        idle(0, 2);
        p = pulses[0];
        send_clean(0, 7, 5, 8'hC0);
        drain();
        chk("post_reset_pulse_count", pulses[0] - p, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
